vc_rr_dequeue: RTL and testbench
================================

VC_RR_DEQUEUE -- requirements
Module: vc_rr_dequeue

Interface
REQ-001 Parameter VCN, default 64, number of virtual channels (VCs) presented by the upstream tagged fifo.
REQ-002 Parameter D, default 11, data width per VC entry.
REQ-003 Parameter CREDITS, default 4, downstream buffer credits per VC; CW = $clog2(CREDITS+1).
REQ-004 Parameter TWIDTH, derived as $clog2(VCN), VC index width.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rstn  input  1  reset, synchronous, active-low.
REQ-007 Port in_data  input  VCN*D  per-VC head data; slice [v*D +: D] belongs to VC v.
REQ-008 Port in_empty_n  input  VCN  per-VC head valid (1 = head entry present).
REQ-009 Port in_re  output  VCN  per-VC pop strobe to upstream fifo; combinational, one-hot or zero.
REQ-010 Port vc_en  input  VCN  per-VC scheduling enable (0 = VC masked).
REQ-011 Port credit_ret  input  VCN  per-VC credit return pulse, one credit per asserted bit per cycle.
REQ-012 Port out_valid  output  1  registered output valid.
REQ-013 Port out_ready  input  1  downstream accept.
REQ-014 Port out_data  output  D  registered output data.
REQ-015 Port out_vc  output  TWIDTH  VC index of out_data.

Function
REQ-016 eligible[v] SHALL be in_empty_n[v] & vc_en[v] & (credit[v] != 0).
REQ-017 slot_free SHALL be ~out_valid | out_ready.
REQ-018 When slot_free and any eligible, exactly one VC SHALL be granted; otherwise in_re SHALL be all-zero.
REQ-019 Grant SHALL be round-robin: search starts at (last_grant+1) mod VCN, wraps, picks first eligible.
REQ-020 last_grant SHALL update to the granted index only on a grant cycle.
REQ-021 in_re[g] SHALL assert in the grant cycle; in_data[g] sampled that cycle SHALL load out_data, g loads out_vc, out_valid sets at next edge (latency 1).
REQ-022 Without a grant, out_valid/out_ready handshake completing SHALL clear out_valid; else out_valid, out_data, out_vc hold.
REQ-023 While out_valid & ~out_ready, out_data and out_vc SHALL be stable and in_re SHALL be zero.
REQ-024 Back-to-back: out_valid & out_ready with a grant SHALL keep out_valid = 1 and load new data (full throughput, one per cycle).
REQ-025 credit[v] SHALL decrement on grant of v, increment on credit_ret[v], and hold when both occur in the same cycle.
REQ-026 credit[v] SHALL never exceed CREDITS; a credit_ret at CREDITS is a protocol error, flagged by assertion, and the count saturates.
REQ-027 Grant with credit[v] == 0 SHALL be impossible (underflow-free by REQ-016).
REQ-028 VCN = 1 SHALL degenerate to a single-VC pass-through with credits; TWIDTH is forced to at least 1.

Reset
REQ-029 On rstn low at clock edge: out_valid = 0, out_data = 0, out_vc = 0, last_grant = VCN-1 (first search starts at VC 0), credit[v] = CREDITS for all v.
REQ-030 During reset in_re SHALL be all-zero regardless of inputs.
REQ-031 Reset mid-transfer SHALL discard the held output word; no in_re asserts in the reset cycle.

Structure
REQ-032 Shared package xl_pkg SHALL hold default VCN, D, CREDITS constants and the vc_idx_t typedef (TWIDTH bits).
REQ-033 Round-robin pick logic SHALL be one sub-module, vc_rr_pick (request vector + last index in; one-hot grant + index + any out).
REQ-034 All flops SHALL use the team's prim_ff_reset primitive.

Verification
REQ-035 Reset, then in_empty_n=0x1 with vc_en all-ones and out_ready=1 -> in_re=0x1 that cycle, next cycle out_valid=1, out_vc=0, out_data=in_data[0].
REQ-036 VC 0,1,2 continuously eligible, out_ready=1 -> grants cycle 0,1,2,0,1,2; out_valid stays 1 every cycle after the first.
REQ-037 CREDITS=4, VC 5 always eligible, no credit_ret -> exactly 4 grants then in_re[5]=0; one credit_ret[5] pulse -> exactly 1 further grant.
REQ-038 out_ready=0 for 3 cycles with out_valid=1 -> in_re=0, out_data/out_vc unchanged; release -> next grant same cycle out_ready rises.
REQ-039 Grant and credit_ret on the same VC in one cycle -> credit unchanged; rstn low mid-stream -> out_valid=0 and all credits = 4 next cycle.

Source files
------------

// File: rtl/xl_pkg.sv
// Shared constants and types for the VC dequeue slice.
package xl_pkg;

  localparam int unsigned VCN_DEF     = 64;
  localparam int unsigned D_DEF       = 11;
  localparam int unsigned CREDITS_DEF = 4;

  // VC index width; never below one bit so a single-VC build still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TWIDTH_DEF = idx_width(VCN_DEF);

  typedef logic [TWIDTH_DEF-1:0] vc_idx_t;

endpackage

// File: rtl/vc_rr_dequeue_if.sv
// Upstream per-VC fifo heads plus the registered downstream output channel.
interface vc_rr_dequeue_if
  import xl_pkg::*;
#(
  parameter int unsigned VCN = VCN_DEF,
  parameter int unsigned D   = D_DEF
);
  localparam int unsigned TWIDTH = idx_width(VCN);

  logic [VCN*D-1:0]  in_data;
  logic [VCN-1:0]    in_empty_n;
  logic [VCN-1:0]    in_re;
  logic              out_valid;
  logic              out_ready;
  logic [D-1:0]      out_data;
  logic [TWIDTH-1:0] out_vc;

  // Dequeue engine side.
  modport master (
    input  in_data, in_empty_n, out_ready,
    output in_re, out_valid, out_data, out_vc
  );

  // Fifo / consumer side.
  modport slave (
    output in_data, in_empty_n, out_ready,
    input  in_re, out_valid, out_data, out_vc
  );

endinterface

// File: rtl/prim_ff_reset.sv
// Enabled register with synchronous active-low reset to a parameter value.
module prim_ff_reset #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins; otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (!rstn)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vc_rr_pick.sv
// Round-robin picker: first requester at or after last+1, wrapping.
module vc_rr_pick #(
  parameter int unsigned N  = 64,
  parameter int unsigned IW = 6
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk the N candidates in rotated order and latch onto the first hit.
  always_comb begin
    logic [IW-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = IW'((32'(last) + 32'd1 + i) % N);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/vc_rr_dequeue.sv
// Credit-gated round-robin dequeue of per-VC fifo heads into one registered
// output slot with full one-word-per-cycle throughput.
module vc_rr_dequeue
  import xl_pkg::*;
#(
  parameter int unsigned VCN     = VCN_DEF,
  parameter int unsigned D       = D_DEF,
  parameter int unsigned CREDITS = CREDITS_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [VCN-1:0] vc_en,
  input  logic [VCN-1:0] credit_ret,
  vc_rr_dequeue_if.master bus
);

  localparam int unsigned TWIDTH = idx_width(VCN);
  localparam int unsigned CW     = $clog2(CREDITS + 1);

  logic [CW-1:0]     credit [VCN];
  logic [VCN-1:0]    eligible;
  logic [VCN-1:0]    req;
  logic [VCN-1:0]    gnt;
  logic [TWIDTH-1:0] gidx;
  logic [TWIDTH-1:0] last_grant;
  logic              gany;
  logic              slot_free;
  logic              out_valid_q;
  logic [D-1:0]      out_data_q;
  logic [TWIDTH-1:0] out_vc_q;

  // A VC may be served when it has a head entry, is enabled and holds a credit.
  always_comb begin
    eligible = '0;
    for (int unsigned v = 0; v < VCN; v++) begin
      eligible[v] = bus.in_empty_n[v] & vc_en[v] & (credit[v] != '0);
    end
  end

  assign slot_free = ~out_valid_q | bus.out_ready;
  // Gating with rstn keeps in_re quiet during the reset cycle.
  assign req       = eligible & {VCN{slot_free & rstn}};

  vc_rr_pick #(.N(VCN), .IW(TWIDTH)) u_pick (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (gany)
  );

  assign bus.in_re = gnt;

  prim_ff_reset #(.W(1), .RST_VAL(1'b0)) u_valid_ff (
    .clk (clk), .rstn (rstn), .en (1'b1),
    .d   (gany | (out_valid_q & ~bus.out_ready)),
    .q   (out_valid_q)
  );

  prim_ff_reset #(.W(D), .RST_VAL('0)) u_data_ff (
    .clk (clk), .rstn (rstn), .en (gany),
    .d   (bus.in_data[gidx*D +: D]),
    .q   (out_data_q)
  );

  prim_ff_reset #(.W(TWIDTH), .RST_VAL('0)) u_vc_ff (
    .clk (clk), .rstn (rstn), .en (gany),
    .d   (gidx),
    .q   (out_vc_q)
  );

  prim_ff_reset #(.W(TWIDTH), .RST_VAL(TWIDTH'(VCN - 1))) u_last_ff (
    .clk (clk), .rstn (rstn), .en (gany),
    .d   (gidx),
    .q   (last_grant)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_vc    = out_vc_q;

  for (genvar v = 0; v < VCN; v++) begin : g_credit
    logic [CW-1:0] nxt;
    logic          upd;

    // Grant takes a credit, a return gives one back; both together cancel.
    always_comb begin
      upd = credit_ret[v] ^ gnt[v];
      nxt = credit[v];
      if (credit_ret[v] & ~gnt[v]) begin
        nxt = (credit[v] == CW'(CREDITS)) ? credit[v] : credit[v] + 1'b1;
      end else if (gnt[v] & ~credit_ret[v]) begin
        nxt = credit[v] - 1'b1;
      end
    end

    prim_ff_reset #(.W(CW), .RST_VAL(CW'(CREDITS))) u_credit_ff (
      .clk (clk), .rstn (rstn), .en (upd), .d (nxt), .q (credit[v])
    );

    credit_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(credit_ret[v] && !gnt[v] && credit[v] == CW'(CREDITS)));
  end

endmodule

// File: tb/tb_vc_rr_dequeue.sv
// Bench for vc_rr_dequeue: vector table plus hand sequences, scoreboarded output.
module tb_vc_rr_dequeue;
  import xl_pkg::*;

  localparam int unsigned VCN = 8;
  localparam int unsigned D   = 11;
  localparam int unsigned TW  = 3;

  typedef struct {
    logic [VCN-1:0] empty_n;
    logic [VCN-1:0] en;
    logic [VCN-1:0] ret;
    logic           ready;
    logic [VCN-1:0] exp_re;
    logic           exp_valid;
  } vec_t;

  typedef struct {
    logic [TW-1:0] vc;
    logic [D-1:0]  data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [VCN-1:0] vc_en = '0;
  logic [VCN-1:0] credit_ret = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned seq    = 0;
  exp_t        sb[$];
  exp_t        last_exp;
  vec_t        tbl[$];

  vc_rr_dequeue_if #(.VCN(VCN), .D(D)) bus ();

  vc_rr_dequeue #(.VCN(VCN), .D(D), .CREDITS(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .vc_en      (vc_en),
    .credit_ret (credit_ret),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] dval(input int unsigned s, input int unsigned v);
    return D'((s * 13 + v * 97 + 5) % 2048);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int unsigned v = 0; v < VCN; v++) bus.in_data[v*D +: D] = dval(seq, v);
  endtask

  // One clock of stimulus: check in_re mid-cycle, outputs just after the edge.
  task automatic run_cycle(input logic [VCN-1:0] empty_n, input logic [VCN-1:0] en,
                           input logic [VCN-1:0] ret, input logic ready,
                           input logic [VCN-1:0] exp_re, input logic exp_valid);
    exp_t e;
    bus.in_empty_n = empty_n;
    vc_en          = en;
    credit_ret     = ret;
    bus.out_ready  = ready;
    drive_data();
    @(negedge clk);
    chk("in_re", 32'(bus.in_re), 32'(exp_re));
    if (exp_re != '0) begin
      for (int unsigned v = 0; v < VCN; v++) begin
        if (exp_re[v]) begin
          e.vc   = TW'(v);
          e.data = dval(seq, v);
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    seq++;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_vc", 32'(bus.out_vc), 32'(e.vc));
      chk("out_data", 32'(bus.out_data), 32'(e.data));
      last_exp = e;
    end else if (exp_valid) begin
      chk("hold_vc", 32'(bus.out_vc), 32'(last_exp.vc));
      chk("hold_data", 32'(bus.out_data), 32'(last_exp.data));
    end
  endtask

  // Single reset cycle with all VCs requesting; ready chosen by caller.
  task automatic do_reset(input logic ready);
    rstn           = 1'b0;
    bus.in_empty_n = '1;
    vc_en          = '1;
    credit_ret     = '0;
    bus.out_ready  = ready;
    drive_data();
    @(negedge clk);
    chk("rst_in_re", 32'(bus.in_re), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("rst_vc", 32'(bus.out_vc), 32'h0);
    rstn = 1'b1;
    sb.delete();
  endtask

  task automatic add(input logic [VCN-1:0] empty_n, input logic [VCN-1:0] en,
                     input logic [VCN-1:0] ret, input logic ready,
                     input logic [VCN-1:0] exp_re, input logic exp_valid);
    vec_t t;
    t.empty_n = empty_n; t.en = en; t.ret = ret; t.ready = ready;
    t.exp_re = exp_re; t.exp_valid = exp_valid;
    tbl.push_back(t);
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_empty_n = '0;
    bus.out_ready  = 1'b0;
    last_exp.vc    = '0;
    last_exp.data  = '0;

    // empty_n, vc_en, credit_ret, ready, expected in_re, expected out_valid
    add(8'h01, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);  // first grant goes to VC0
    add(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);  // drained
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1);  // rotate 1,2,0,1,2,0
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);
    add(8'h07, 8'hFE, 8'h00, 1'b1, 8'h02, 1'b1);  // VC0 masked
    add(8'h07, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);  // stall x3: hold
    add(8'h07, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b1);  // release: grant same cycle
    add(8'hA0, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b1);  // sparse VCs 5,7
    add(8'hA0, 8'hFF, 8'h00, 1'b1, 8'h80, 1'b1);
    add(8'hA0, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);  // wrap 6,7 -> 0; last credits
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b1);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);  // VCs 0..2 out of credit
    add(8'h07, 8'hFF, 8'h02, 1'b1, 8'h00, 1'b0);  // return lands next cycle
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1);
    add(8'h07, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b0);
    add(8'h07, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);
    add(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);

    do_reset(1'b1);
    foreach (tbl[i]) begin
      run_cycle(tbl[i].empty_n, tbl[i].en, tbl[i].ret, tbl[i].ready,
                tbl[i].exp_re, tbl[i].exp_valid);
    end

    // Credit exhaustion on VC5, then one return buys one more grant.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) run_cycle(8'h20, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b1);
    for (int i = 0; i < 2; i++) run_cycle(8'h20, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);
    run_cycle(8'h20, 8'hFF, 8'h20, 1'b1, 8'h00, 1'b0);
    run_cycle(8'h20, 8'hFF, 8'h00, 1'b1, 8'h20, 1'b1);
    for (int i = 0; i < 2; i++) run_cycle(8'h20, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);

    // Grant and return on VC3 in the same cycle leave the count unchanged,
    // so five grants fit before it runs dry.
    do_reset(1'b1);
    run_cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h08, 1'b1);
    run_cycle(8'h08, 8'hFF, 8'h08, 1'b1, 8'h08, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h08, 1'b1);
    run_cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);

    // Reset with a stalled word in the slot: word dropped, credits refilled.
    run_cycle(8'hFF, 8'hFF, 8'h00, 1'b1, 8'h10, 1'b1);
    do_reset(1'b0);
    run_cycle(8'hFF, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h08, 1'b1);
    run_cycle(8'h08, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
